// File: rtl/instruction_fetch_unit.sv
// Instruction-fetch stage for the 16-bit RISC pipeline: owns the PC, drives
// instruction memory, loads IF/ID, and honours branch redirects and HALT.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_WORD  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pcsrc,
  input  logic        pcsrc2,
  input  logic [15:0] bra_pc,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc1,
  output logic        if_id_valid,
  output logic        flush_id_exe,
  output logic        halted
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_pc1;
  logic        r_valid;
  logic [15:0] w_pc_nxt;
  logic [15:0] w_instr_nxt;
  logic [15:0] w_pc1_nxt;
  logic        w_valid_nxt;
  logic [15:0] w_pc_inc;

  // 16-bit add wraps FFFF -> 0000 naturally.
  assign w_pc_inc = r_pc + 16'd1;

  always_comb begin
    // NOTE: every output of this block gets a default (hold) first, so no
    // path can leave a signal unassigned and infer a latch.
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_pc1_nxt   = r_pc1;
    w_valid_nxt = r_valid;

    if (pcsrc) begin
      // Redirect wins over stall and discards whatever was fetched, HALT included.
      w_state_nxt = ST_RUN;
      w_pc_nxt    = bra_pc;
      w_instr_nxt = NOP_WORD;
      w_pc1_nxt   = 16'h0000;
      w_valid_nxt = 1'b0;
    end else if (!stall) begin
      unique case (r_state)
        ST_RUN: begin
          w_pc1_nxt   = w_pc_inc;
          w_valid_nxt = 1'b1;
          if (imem_data == HALT_WORD) begin
            // PC stays on the halt so a resume-by-redirect is the only way out.
            w_instr_nxt = HALT_WORD;
            w_state_nxt = ST_HALT;
          end else begin
            w_instr_nxt = imem_data;
            w_pc_nxt    = w_pc_inc;
          end
        end
        ST_HALT: begin
          w_instr_nxt = NOP_WORD;
          w_pc1_nxt   = 16'h0000;
          w_valid_nxt = 1'b0;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_instr <= NOP_WORD;
      r_pc1   <= 16'h0000;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_pc1   <= w_pc1_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign imem_addr    = r_pc;
  assign if_id_instr  = r_instr;
  assign if_id_pc1    = r_pc1;
  assign if_id_valid  = r_valid;
  assign flush_id_exe = pcsrc2;
  assign halted       = (r_state == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: imem[a] = 16'h1000 + a, with an
// optional HALT word planted at address 3.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        pcsrc;
  logic        pcsrc2;
  logic [15:0] bra_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc1;
  logic        if_id_valid;
  logic        flush_id_exe;
  logic        halted;
  logic        halt_en;

  int errors = 0;
  int checks = 0;

  instruction_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .pcsrc        (pcsrc),
    .pcsrc2       (pcsrc2),
    .bra_pc       (bra_pc),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .if_id_instr  (if_id_instr),
    .if_id_pc1    (if_id_pc1),
    .if_id_valid  (if_id_valid),
    .flush_id_exe (flush_id_exe),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  assign imem_data = (halt_en && imem_addr == 16'h0003) ? 16'hFFFF : 16'h1000 + imem_addr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [15:0] target);
    pcsrc  = 1'b1;
    bra_pc = target;
    step();
    pcsrc  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; pcsrc = 1'b0; pcsrc2 = 1'b0; bra_pc = 16'h0; halt_en = 1'b0;
    step();
    step();
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h exp 0000", imem_addr); end
    checks++; if (if_id_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h exp 0000", if_id_instr); end
    checks++; if (if_id_pc1 !== 16'h0000) begin errors++; $display("FAIL reset_pc1: got %h exp 0000", if_id_pc1); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", if_id_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b exp 0", halted); end
  endtask

  task automatic test_free_run();
    rst = 1'b0;
    step();
    checks++; if (imem_addr !== 16'h0001) begin errors++; $display("FAIL run1_pc: got %h exp 0001", imem_addr); end
    checks++; if (if_id_instr !== 16'h1000) begin errors++; $display("FAIL run1_instr: got %h exp 1000", if_id_instr); end
    checks++; if (if_id_pc1 !== 16'h0001) begin errors++; $display("FAIL run1_pc1: got %h exp 0001", if_id_pc1); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL run1_valid: got %b exp 1", if_id_valid); end
    step();
    checks++; if (imem_addr !== 16'h0002) begin errors++; $display("FAIL run2_pc: got %h exp 0002", imem_addr); end
    checks++; if (if_id_instr !== 16'h1001) begin errors++; $display("FAIL run2_instr: got %h exp 1001", if_id_instr); end
    checks++; if (if_id_pc1 !== 16'h0002) begin errors++; $display("FAIL run2_pc1: got %h exp 0002", if_id_pc1); end
  endtask

  task automatic test_id_branch();
    step(); step(); step();
    checks++; if (imem_addr !== 16'h0005) begin errors++; $display("FAIL idb_pre_pc: got %h exp 0005", imem_addr); end
    pcsrc = 1'b1; bra_pc = 16'h0040;
    #1;
    checks++; if (flush_id_exe !== 1'b0) begin errors++; $display("FAIL idb_flush: got %b exp 0", flush_id_exe); end
    step();
    pcsrc = 1'b0;
    checks++; if (imem_addr !== 16'h0040) begin errors++; $display("FAIL idb_pc: got %h exp 0040", imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL idb_bubble: got %b exp 0", if_id_valid); end
    step();
    checks++; if (if_id_instr !== 16'h1040) begin errors++; $display("FAIL idb_instr: got %h exp 1040", if_id_instr); end
    checks++; if (if_id_pc1 !== 16'h0041) begin errors++; $display("FAIL idb_pc1: got %h exp 0041", if_id_pc1); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL idb_valid: got %b exp 1", if_id_valid); end
  endtask

  task automatic test_exe_branch_stall();
    stall = 1'b1; pcsrc = 1'b1; pcsrc2 = 1'b1; bra_pc = 16'h0100;
    #1;
    checks++; if (flush_id_exe !== 1'b1) begin errors++; $display("FAIL exb_flush: got %b exp 1", flush_id_exe); end
    step();
    stall = 1'b0; pcsrc = 1'b0; pcsrc2 = 1'b0;
    checks++; if (imem_addr !== 16'h0100) begin errors++; $display("FAIL exb_pc: got %h exp 0100", imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL exb_bubble: got %b exp 0", if_id_valid); end
    checks++; if (flush_id_exe !== 1'b0) begin errors++; $display("FAIL exb_flush_off: got %b exp 0", flush_id_exe); end
  endtask

  task automatic test_stall_hold();
    redirect(16'h0006);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_addr !== 16'h0007) begin errors++; $display("FAIL stall_pc[%0d]: got %h exp 0007", i, imem_addr); end
      checks++; if (if_id_instr !== 16'h1006 || if_id_pc1 !== 16'h0007 || if_id_valid !== 1'b1) begin
        errors++; $display("FAIL stall_ifid[%0d]: got %h/%h/%b exp 1006/0007/1", i, if_id_instr, if_id_pc1, if_id_valid);
      end
    end
    stall = 1'b0;
    step();
    checks++; if (imem_addr !== 16'h0008) begin errors++; $display("FAIL unstall_pc: got %h exp 0008", imem_addr); end
    checks++; if (if_id_instr !== 16'h1007 || if_id_pc1 !== 16'h0008) begin
      errors++; $display("FAIL unstall_ifid: got %h/%h exp 1007/0008", if_id_instr, if_id_pc1);
    end
  endtask

  task automatic test_halt();
    halt_en = 1'b1;
    redirect(16'h0002);
    step();
    checks++; if (imem_addr !== 16'h0003) begin errors++; $display("FAIL halt_pre_pc: got %h exp 0003", imem_addr); end
    step();
    checks++; if (if_id_instr !== 16'hFFFF || if_id_pc1 !== 16'h0004 || if_id_valid !== 1'b1) begin
      errors++; $display("FAIL halt_ifid: got %h/%h/%b exp FFFF/0004/1", if_id_instr, if_id_pc1, if_id_valid);
    end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_state: got %b exp 1", halted); end
    checks++; if (imem_addr !== 16'h0003) begin errors++; $display("FAIL halt_pc: got %h exp 0003", imem_addr); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (imem_addr !== 16'h0003 || halted !== 1'b1) begin
        errors++; $display("FAIL halt_hold_pc[%0d]: got %h/%b exp 0003/1", i, imem_addr, halted);
      end
      checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0000) begin
        errors++; $display("FAIL halt_bubble[%0d]: got %h/%b exp 0000/0", i, if_id_instr, if_id_valid);
      end
    end
    redirect(16'h0010);
    checks++; if (imem_addr !== 16'h0010) begin errors++; $display("FAIL resume_pc: got %h exp 0010", imem_addr); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL resume_state: got %b exp 0", halted); end
    step();
    checks++; if (if_id_instr !== 16'h1010 || if_id_valid !== 1'b1) begin
      errors++; $display("FAIL resume_ifid: got %h/%b exp 1010/1", if_id_instr, if_id_valid);
    end
    // A redirect on the same edge as a HALT fetch must discard the halt.
    redirect(16'h0003);
    redirect(16'h0020);
    checks++; if (halted !== 1'b0 || imem_addr !== 16'h0020 || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL halt_discard: got %b/%h/%b exp 0/0020/0", halted, imem_addr, if_id_valid);
    end
    halt_en = 1'b0;
  endtask

  task automatic test_wrap();
    redirect(16'hFFFE);
    checks++; if (imem_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap_pc0: got %h exp FFFE", imem_addr); end
    step();
    checks++; if (imem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_pc1: got %h exp FFFF", imem_addr); end
    checks++; if (if_id_pc1 !== 16'hFFFF) begin errors++; $display("FAIL wrap_pc1_fffe: got %h exp FFFF", if_id_pc1); end
    step();
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_pc2: got %h exp 0000", imem_addr); end
    checks++; if (if_id_instr !== 16'h0FFF || if_id_pc1 !== 16'h0000) begin
      errors++; $display("FAIL wrap_ifid: got %h/%h exp 0FFF/0000", if_id_instr, if_id_pc1);
    end
  endtask

  task automatic test_reset_mid_halt();
    halt_en = 1'b1;
    redirect(16'h0003);
    step();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL rmh_enter: got %b exp 1", halted); end
    rst = 1'b1; stall = 1'b1;
    step();
    rst = 1'b0; stall = 1'b0; halt_en = 1'b0;
    checks++; if (halted !== 1'b0 || imem_addr !== 16'h0000 || if_id_valid !== 1'b0 || if_id_pc1 !== 16'h0000) begin
      errors++; $display("FAIL rmh_state: got %b/%h/%b/%h exp 0/0000/0/0000", halted, imem_addr, if_id_valid, if_id_pc1);
    end
    step();
    checks++; if (if_id_instr !== 16'h1000 || imem_addr !== 16'h0001) begin
      errors++; $display("FAIL rmh_restart: got %h/%h exp 1000/0001", if_id_instr, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_id_branch();
    test_exe_branch_stall();
    test_stall_hold();
    test_halt();
    test_wrap();
    test_reset_mid_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
